// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_WAIT_CYCLES = 4;
    localparam int CTR_W               = 8;

endpackage

// File: rtl/mem_wait_ctr.sv
// Memory wait-state down-counter; done flags the final wait cycle.
module mem_wait_ctr
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CTR_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    // A zero count also reports done so a stray WAIT entry can never hang.
    assign done = (count <= CTR_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one wait-stated memory between two cache controllers.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int AW          = 16,
    parameter int DW          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Strobe0,
    input  logic          Strobe1,
    input  logic          RW0,
    input  logic          RW1,
    input  logic [AW-1:0] Addr0,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] WData0,
    input  logic [DW-1:0] WData1,
    output logic          MReady0,
    output logic          MReady1,
    output logic [DW-1:0] RData,
    output logic          MemStrobe,
    output logic          MemRW,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    output logic          Busy,
    output logic          Grant
);

    state_t state, state_nxt;
    logic   pending0, pending1;
    logic   prio;
    logic   req0, req1, grant_sel, start;
    logic   accept0, accept1;
    logic   ctr_load, ctr_en, ctr_done;

    assign req0      = Strobe0 | pending0;
    assign req1      = Strobe1 | pending1;
    assign grant_sel = (req0 && req1) ? prio : req1;
    assign start     = (state == ST_IDLE) && (req0 || req1);

    // A requester already queued or currently being served cannot queue again.
    assign accept0 = Strobe0 && !pending0 && !(Busy && !Grant);
    assign accept1 = Strobe1 && !pending1 && !(Busy && Grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ctr_load  = 1'b0;
        ctr_en    = 1'b0;
        case (state)
            ST_IDLE:  if (req0 || req1) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                ctr_load  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                ctr_en = 1'b1;
                if (ctr_done) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending0 <= 1'b0;
            pending1 <= 1'b0;
        end else begin
            if (state == ST_DONE && !Grant) pending0 <= 1'b0;
            else if (accept0)               pending0 <= 1'b1;
            if (state == ST_DONE && Grant)  pending1 <= 1'b0;
            else if (accept1)               pending1 <= 1'b1;
        end
    end

    // Grant, the round-robin pointer and the memory command change only at access start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Grant    <= 1'b0;
            prio     <= 1'b0;
            MemRW    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
        end else if (start) begin
            Grant    <= grant_sel;
            prio     <= ~grant_sel;
            MemRW    <= grant_sel ? RW1    : RW0;
            MemAddr  <= grant_sel ? Addr1  : Addr0;
            MemWData <= grant_sel ? WData1 : WData0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RData <= '0;
        end else if (state == ST_WAIT && ctr_done && !MemRW) begin
            RData <= MemRData;
        end
    end

    mem_wait_ctr u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (CTR_W'(WAIT_CYCLES)),
        .en       (ctr_en),
        .done     (ctr_done)
    );

    assign MemStrobe = (state == ST_ISSUE);
    assign Busy      = (state != ST_IDLE);
    assign MReady0   = (state == ST_DONE) && !Grant;
    assign MReady1   = (state == ST_DONE) && Grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with WAIT_CYCLES=4; cycle 0 is the strobe cycle.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        Strobe0, Strobe1, RW0, RW1;
    logic [15:0] Addr0, Addr1;
    logic [31:0] WData0, WData1;
    logic        MReady0, MReady1;
    logic [31:0] RData;
    logic        MemStrobe, MemRW;
    logic [15:0] MemAddr;
    logic [31:0] MemWData, MemRData;
    logic        Busy, Grant;

    int compared   = 0;
    int mismatched = 0;
    int pulses0, pulses1, strobes;

    mem_arbiter #(.WAIT_CYCLES(4), .AW(16), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .Strobe0   (Strobe0),
        .Strobe1   (Strobe1),
        .RW0       (RW0),
        .RW1       (RW1),
        .Addr0     (Addr0),
        .Addr1     (Addr1),
        .WData0    (WData0),
        .WData1    (WData1),
        .MReady0   (MReady0),
        .MReady1   (MReady1),
        .RData     (RData),
        .MemStrobe (MemStrobe),
        .MemRW     (MemRW),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemRData  (MemRData),
        .Busy      (Busy),
        .Grant     (Grant)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   Busy, 0);
        chk({tag, "_grant"},  Grant, 0);
        chk({tag, "_mrdy0"},  MReady0, 0);
        chk({tag, "_mrdy1"},  MReady1, 0);
        chk({tag, "_mstb"},   MemStrobe, 0);
        chk({tag, "_mrw"},    MemRW, 0);
        chk({tag, "_maddr"},  MemAddr, 0);
        chk({tag, "_mwdata"}, MemWData, 0);
        chk({tag, "_rdata"},  RData, 0);
    endtask

    initial begin
        reset = 1'b1;
        Strobe0 = 0; Strobe1 = 0; RW0 = 0; RW1 = 0;
        Addr0 = 16'h0010; Addr1 = 16'h00A4;
        WData0 = 32'h0BAD_F00D; WData1 = 32'hDEADBEEF;
        MemRData = 32'h12345678;
        tick(); tick();
        chk_all_zero("rst");
        reset = 1'b0;
        tick();

        // Read from requester 0
        Strobe0 = 1; RW0 = 0;
        tick();
        Strobe0 = 0;
        chk("rd_mstb_c1", MemStrobe, 1);
        chk("rd_mrw_c1", MemRW, 0);
        chk("rd_maddr_c1", MemAddr, 16'h0010);
        chk("rd_grant_c1", Grant, 0);
        chk("rd_busy_c1", Busy, 1);
        for (int c = 2; c <= 6; c++) begin
            tick();
            chk($sformatf("rd_mstb_c%0d", c), MemStrobe, 0);
            chk($sformatf("rd_maddr_c%0d", c), MemAddr, 16'h0010);
            chk($sformatf("rd_mrdy0_c%0d", c), MReady0, (c == 6));
            chk($sformatf("rd_mrdy1_c%0d", c), MReady1, 0);
        end
        chk("rd_rdata_c6", RData, 32'h12345678);
        tick();
        chk("rd_busy_c7", Busy, 0);

        // Write from requester 1; RData must keep the earlier read value
        MemRData = 32'hCAFEF00D;
        Strobe1 = 1; RW1 = 1;
        tick();
        Strobe1 = 0;
        chk("wr_mstb_c1", MemStrobe, 1);
        chk("wr_mrw_c1", MemRW, 1);
        chk("wr_maddr_c1", MemAddr, 16'h00A4);
        chk("wr_mwdata_c1", MemWData, 32'hDEADBEEF);
        chk("wr_grant_c1", Grant, 1);
        for (int c = 2; c <= 6; c++) begin
            tick();
            chk($sformatf("wr_mrw_c%0d", c), MemRW, 1);
            chk($sformatf("wr_mrdy1_c%0d", c), MReady1, (c == 6));
            chk($sformatf("wr_mrdy0_c%0d", c), MReady0, 0);
        end
        chk("wr_rdata_c6", RData, 32'h12345678);
        tick();

        // Simultaneous requests straight after reset: requester 0 first
        reset = 1'b1;
        tick();
        reset = 1'b0; RW0 = 0; RW1 = 0;
        tick();
        Strobe0 = 1; Strobe1 = 1;
        tick();
        Strobe0 = 0; Strobe1 = 0;
        chk("sim_grant_c1", Grant, 0);
        chk("sim_maddr_c1", MemAddr, 16'h0010);
        for (int c = 1; c <= 13; c++) begin
            if (c > 1) tick();
            chk($sformatf("sim_mstb_c%0d", c), MemStrobe, (c == 1 || c == 8));
            chk($sformatf("sim_mrdy0_c%0d", c), MReady0, (c == 6));
            chk($sformatf("sim_mrdy1_c%0d", c), MReady1, (c == 13));
            if (c == 7) chk("sim_busy_c7", Busy, 0);
            if (c == 8) chk("sim_grant_c8", Grant, 1);
            if (c == 8) chk("sim_maddr_c8", MemAddr, 16'h00A4);
        end
        tick();

        // Requester 0 served alone, then simultaneous requests favour requester 1
        Strobe0 = 1;
        tick();
        Strobe0 = 0;
        chk("rr_solo_grant", Grant, 0);
        for (int c = 2; c <= 7; c++) tick();
        chk("rr_solo_idle", Busy, 0);
        Strobe0 = 1; Strobe1 = 1;
        tick();
        Strobe0 = 0; Strobe1 = 0;
        chk("rr_grant_c1", Grant, 1);
        chk("rr_maddr_c1", MemAddr, 16'h00A4);
        for (int c = 2; c <= 13; c++) begin
            tick();
            chk($sformatf("rr_mrdy1_c%0d", c), MReady1, (c == 6));
            chk($sformatf("rr_mrdy0_c%0d", c), MReady0, (c == 13));
        end
        tick();

        // Reset at cycle 3 aborts the access; a fresh strobe at cycle 5 completes at 11
        MemRData = 32'h5555AAAA;
        Strobe0 = 1;
        tick();
        Strobe0 = 0;
        tick(); tick();
        reset = 1'b1;
        #1;
        chk_all_zero("abort_c3");
        tick();
        reset = 1'b0;
        chk("abort_busy_c4", Busy, 0);
        chk("abort_mrdy0_c4", MReady0, 0);
        tick();
        chk("abort_busy_c5", Busy, 0);
        Strobe0 = 1;
        for (int c = 6; c <= 12; c++) begin
            tick();
            Strobe0 = 0;
            chk($sformatf("abort_mstb_c%0d", c), MemStrobe, (c == 6));
            chk($sformatf("abort_mrdy0_c%0d", c), MReady0, (c == 11));
        end
        chk("abort_rdata", RData, 32'h5555AAAA);

        // Repeated strobes during requester 0's WAIT give one access only
        pulses0 = 0; pulses1 = 0; strobes = 0;
        Strobe0 = 1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            Strobe0 = (c >= 2 && c <= 4);
            if (MReady0) pulses0++;
            if (MReady1) pulses1++;
            if (MemStrobe) strobes++;
            if (c == 6) chk("rep_mrdy0_c6", MReady0, 1);
            if (c == 8) chk("rep_busy_c8", Busy, 0);
        end
        chk("rep_pulses0", pulses0, 1);
        chk("rep_pulses1", pulses1, 0);
        chk("rep_strobes", strobes, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 4, the memory wait states per access (legal 1..255).
REQ-002 The block SHALL have parameter AW, default 16, the address width.
REQ-003 The block SHALL have parameter DW, default 32, the data width.
REQ-004 clk  input  1  sole clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 Strobe0, Strobe1  input  1 each  one-cycle access request pulse from cache controller 0 / 1.
REQ-007 RW0, RW1  input  1 each  0=read, 1=write; sampled with the request.
REQ-008 Addr0, Addr1  input  AW each  access address; requester holds it stable until its MReady.
REQ-009 WData0, WData1  input  DW each  write data; held like Addr.
REQ-010 MReady0, MReady1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-011 RData  output  DW  read data shared by both requesters; valid while the matching MReady is high.
REQ-012 MemStrobe, MemRW  output  1 each  memory access pulse and direction.
REQ-013 MemAddr, MemWData  output  AW / DW  memory address and write data.
REQ-014 MemRData  input  DW  memory read data; valid in the last WAIT cycle.
REQ-015 Busy, Grant  output  1 each  access in progress; index of the requester being served.

Function
REQ-016 The block SHALL latch a pending flag per requester on its Strobe and clear it in DONE for that requester.
REQ-017 The block SHALL ignore a Strobe from a requester whose flag is already set or that is currently granted.
REQ-018 The FSM SHALL have four states, IDLE, ISSUE, WAIT and DONE, stored in a 2-bit encoding.
REQ-019 In IDLE, with a request (Strobe or pending flag) from either requester, the FSM SHALL go to ISSUE on the next edge; otherwise it SHALL stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not served last; after reset, requester 0 wins.
REQ-021 ISSUE SHALL last one cycle, with MemStrobe=1, MemRW/MemAddr/MemWData from the granted requester, and the counter loaded with WAIT_CYCLES.
REQ-022 WAIT SHALL last exactly WAIT_CYCLES cycles with MemStrobe=0 and the Mem* address/data/direction held.
REQ-023 On the WAIT->DONE edge, RData SHALL capture MemRData for reads and keep its previous value for writes.
REQ-024 DONE SHALL last one cycle with MReady[Grant]=1, then go to IDLE; the other MReady SHALL stay 0.
REQ-025 Latency: a Strobe in IDLE at cycle T SHALL give MemStrobe at T+1 and MReady at T+2+WAIT_CYCLES.
REQ-026 A request arriving during ISSUE, WAIT or DONE SHALL be served next, via IDLE, with one IDLE cycle minimum between accesses.
REQ-027 Busy SHALL be 1 in ISSUE, WAIT and DONE; Grant SHALL be updated only on IDLE->ISSUE.
REQ-028 The counter SHALL be 8 bits, decrement once per WAIT cycle and never wrap.

Reset
REQ-029 Reset SHALL force IDLE, clear both pending flags, set the round-robin pointer to favour requester 0, and set every output to 0.
REQ-030 Reset asserted mid-access SHALL abort the access without producing any MReady pulse.

Structure
REQ-031 The package mem_arb_pkg SHALL hold the state enum typedef and the default WAIT_CYCLES constant.
REQ-032 The wait counter SHALL be one sub-module, mem_wait_ctr (inputs load, load value; output done), instantiated once.

Verification (WAIT_CYCLES=4)
REQ-033 Strobe0 read at cycle 0, Addr0=16'h0010, MemRData=32'h12345678 -> MemStrobe=1 at cycle 1, MemRW=0, MReady0=1 at cycle 6, RData=32'h12345678.
REQ-034 Strobe1 write at cycle 0, Addr1=16'h00A4, WData1=32'hDEADBEEF -> MemStrobe=1, MemRW=1, MemAddr=16'h00A4, MemWData=32'hDEADBEEF at cycle 1; MReady1=1 at cycle 6.
REQ-035 Strobe0 and Strobe1 both at cycle 0 after reset -> MReady0 at 6, MemStrobe for requester 1 at 8, MReady1 at 13.
REQ-036 After requester 0 is served, simultaneous strobes -> Grant=1 first (round-robin).
REQ-037 Reset pulse at cycle 3 of an access -> all outputs 0 at once, no MReady pulse, and a new Strobe0 at cycle 5 completes at cycle 11.
REQ-038 Repeated Strobe0 during requester 0's WAIT -> exactly one MReady0 pulse, with no extra access issued.
